// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative RISC-V M-extension unit:
// funct3 op codes, FSM state encoding and op-class helpers.
package muldiv_pkg;

  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_MULHU  = 3'd3;
  localparam logic [2:0] OP_DIV    = 3'd4;
  localparam logic [2:0] OP_DIVU   = 3'd5;
  localparam logic [2:0] OP_REM    = 3'd6;
  localparam logic [2:0] OP_REMU   = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CALC,
    ST_FIXUP,
    ST_DONE
  } state_t;

  function automatic logic is_div(input logic [2:0] op);
    return op[2];
  endfunction

  function automatic logic is_signed_a(input logic [2:0] op);
    return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic is_signed_b(input logic [2:0] op);
    return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage

// File: rtl/muldiv_iter_core.sv
// Unsigned one-bit-per-cycle datapath: shift-add multiply or restoring divide.
// r_hi/r_lo hold the 2*XLEN product, or remainder/quotient when dividing.
module muldiv_iter_core #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_load,
  input  logic            i_step,
  input  logic            i_isDiv,
  input  logic [XLEN-1:0] i_a,
  input  logic [XLEN-1:0] i_b,
  output logic            o_last,
  output logic [XLEN-1:0] o_hi,
  output logic [XLEN-1:0] o_lo
);

  localparam int CW = $clog2(XLEN + 1);

  logic [CW-1:0]   r_cnt;
  logic [XLEN-1:0] r_hi;
  logic [XLEN-1:0] r_lo;
  logic [XLEN-1:0] r_b;
  logic            r_isDiv;

  logic [XLEN:0]   w_addend;
  logic [XLEN:0]   w_sum;
  logic [XLEN:0]   w_shifted;
  logic            w_geq;
  logic [XLEN-1:0] w_diff;

  // The trial difference only matters when it is non-negative, so XLEN bits suffice.
  always_comb begin
    w_addend  = r_lo[0] ? {1'b0, r_b} : '0;
    w_sum     = {1'b0, r_hi} + w_addend;
    w_shifted = {r_hi, r_lo[XLEN-1]};
    w_geq     = (w_shifted >= {1'b0, r_b});
    w_diff    = w_shifted[XLEN-1:0] - r_b;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_b     <= '0;
      r_isDiv <= 1'b0;
    end else if (i_load) begin
      r_cnt   <= CW'(XLEN);
      r_hi    <= '0;
      r_lo    <= i_a;
      r_b     <= i_b;
      r_isDiv <= i_isDiv;
    end else if (i_step) begin
      r_cnt <= r_cnt - CW'(1);
      if (r_isDiv) begin
        if (w_geq) begin
          r_hi <= w_diff;
          r_lo <= {r_lo[XLEN-2:0], 1'b1};
        end else begin
          r_hi <= w_shifted[XLEN-1:0];
          r_lo <= {r_lo[XLEN-2:0], 1'b0};
        end
      end else begin
        r_hi <= w_sum[XLEN:1];
        r_lo <= {w_sum[0], r_lo[XLEN-1:1]};
      end
    end
  end

  assign o_last = (r_cnt == CW'(1));
  assign o_hi   = r_hi;
  assign o_lo   = r_lo;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit: FSM, divide special cases, sign fix-up
// and the result register around the unsigned iteration core.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            Start,
  input  logic [2:0]      Op,
  input  logic [XLEN-1:0] A,
  input  logic [XLEN-1:0] B,
  input  logic            Flush,
  output logic            Ready,
  output logic            Done,
  output logic [XLEN-1:0] Result
);

  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_t          r_state;
  logic [2:0]      r_op;
  logic            r_negA;
  logic            r_negB;
  logic            r_special;
  logic [XLEN-1:0] r_specialRes;
  logic [XLEN-1:0] r_result;

  logic            w_negA;
  logic            w_negB;
  logic [XLEN-1:0] w_magA;
  logic [XLEN-1:0] w_magB;
  logic            w_bZero;
  logic            w_ovf;
  logic            w_special;
  logic [XLEN-1:0] w_specialRes;
  logic            w_accept;
  logic            w_last;
  logic [XLEN-1:0] w_hi;
  logic [XLEN-1:0] w_lo;
  logic [2*XLEN-1:0] w_prod;
  logic [XLEN-1:0] w_quot;
  logic [XLEN-1:0] w_rem;
  logic [XLEN-1:0] w_fixRes;

  assign Ready    = (r_state == ST_IDLE) || (r_state == ST_DONE);
  assign Done     = (r_state == ST_DONE);
  assign Result   = r_result;
  assign w_accept = Ready && Start && !Flush;

  // Special divides bypass the core; their answer is parked until FIXUP.
  always_comb begin
    w_negA  = is_signed_a(Op) && A[XLEN-1];
    w_negB  = is_signed_b(Op) && B[XLEN-1];
    w_magA  = w_negA ? -A : A;
    w_magB  = w_negB ? -B : B;
    w_bZero = (B == '0);
    w_ovf   = ((Op == OP_DIV) || (Op == OP_REM)) && (A == MOST_NEG) && (B == '1);
    w_special = is_div(Op) && (w_bZero || w_ovf);
    if (w_bZero) w_specialRes = Op[1] ? A : '1;
    else         w_specialRes = Op[1] ? '0 : A;
  end

  muldiv_iter_core #(
    .XLEN (XLEN)
  ) u_core (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_load  (w_accept && !w_special),
    .i_step  ((r_state == ST_CALC) && !Flush),
    .i_isDiv (is_div(Op)),
    .i_a     (w_magA),
    .i_b     (w_magB),
    .o_last  (w_last),
    .o_hi    (w_hi),
    .o_lo    (w_lo)
  );

  always_comb begin
    w_prod = {w_hi, w_lo};
    if (r_negA ^ r_negB) w_prod = -{w_hi, w_lo};
    w_quot = (r_negA ^ r_negB) ? -w_lo : w_lo;
    w_rem  = r_negA ? -w_hi : w_hi;
    case (r_op)
      OP_MUL:                        w_fixRes = w_prod[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU:  w_fixRes = w_prod[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:               w_fixRes = w_quot;
      OP_REM, OP_REMU:               w_fixRes = w_rem;
      default:                       w_fixRes = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_op         <= '0;
      r_negA       <= 1'b0;
      r_negB       <= 1'b0;
      r_special    <= 1'b0;
      r_specialRes <= '0;
      r_result     <= '0;
    end else if (Flush) begin
      r_state <= ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (Start) begin
            r_op         <= Op;
            r_negA       <= w_negA;
            r_negB       <= w_negB;
            r_special    <= w_special;
            r_specialRes <= w_specialRes;
            r_state      <= w_special ? ST_FIXUP : ST_CALC;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_CALC: begin
          if (w_last) r_state <= ST_FIXUP;
        end
        ST_FIXUP: begin
          r_result <= r_special ? r_specialRes : w_fixRes;
          r_state  <= ST_DONE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed cases plus randomized ops
// compared against a plain-arithmetic model of the M-extension semantics.
module tb_muldiv_unit;

  localparam logic [31:0] MIN_INT = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        Start;
  logic [2:0]  Op;
  logic [31:0] A;
  logic [31:0] B;
  logic        Flush;
  logic        Ready;
  logic        Done;
  logic [31:0] Result;

  int checkCount = 0;
  int failCount  = 0;
  logic [31:0] lastExp = 32'h0;

  always #5 clk = ~clk;

  muldiv_unit #(
    .XLEN (32)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .Start  (Start),
    .Op     (Op),
    .A      (A),
    .B      (B),
    .Flush  (Flush),
    .Ready  (Ready),
    .Done   (Done),
    .Result (Result)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Reference semantics written with 64-bit and native signed arithmetic.
  function automatic logic [31:0] refResult(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub, p;
    int ia, ib;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'h0, a};
    ub = {32'h0, b};
    ia = $signed(a);
    ib = $signed(b);
    case (op)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 32'h0) return 32'hFFFF_FFFF;
        if (a == MIN_INT && b == 32'hFFFF_FFFF) return a;
        return 32'(ia / ib);
      end
      3'd5: begin
        if (b == 32'h0) return 32'hFFFF_FFFF;
        return a / b;
      end
      3'd6: begin
        if (b == 32'h0) return a;
        if (a == MIN_INT && b == 32'hFFFF_FFFF) return 32'h0;
        return 32'(ia % ib);
      end
      default: begin
        if (b == 32'h0) return a;
        return a % b;
      end
    endcase
  endfunction

  function automatic int refLatency(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op >= 3'd4 && b == 32'h0) return 1;
    if ((op == 3'd4 || op == 3'd6) && a == MIN_INT && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  function automatic logic [31:0] pickOperand();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return MIN_INT;
      3:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // Issues one op, scrambles the operands after accept, then times Done.
  task automatic applyStimulus(input string tag, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] expRes;
    int lat;
    expRes = refResult(op, a, b);
    @(negedge clk);
    Start = 1'b1;
    Op = op;
    A = a;
    B = b;
    @(posedge clk);
    #1;
    Start = 1'b0;
    Op = 3'($urandom);
    A = $urandom;
    B = $urandom;
    checkOutput({tag, ".busy"}, 32'(Ready), 32'h0);
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!Done && lat < 60);
    checkOutput({tag, ".latency"}, 32'(lat), 32'(refLatency(op, a, b)));
    checkOutput({tag, ".result"}, Result, expRes);
    checkOutput({tag, ".ready"}, 32'(Ready), 32'h1);
    lastExp = expRes;
  endtask

  task automatic countDone(input int cycles, output int seen);
    seen = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (Done) seen++;
    end
  endtask

  initial begin
    int seen;
    logic [2:0] rop;
    rst_n = 1'b0;
    Start = 1'b0;
    Flush = 1'b0;
    Op = 3'd0;
    A = 32'h0;
    B = 32'h0;
    repeat (3) @(negedge clk);
    checkOutput("reset.ready", 32'(Ready), 32'h1);
    checkOutput("reset.done", 32'(Done), 32'h0);
    checkOutput("reset.result", Result, 32'h0);
    rst_n = 1'b1;

    applyStimulus("mul_7x-3", 3'd0, 32'd7, 32'hFFFF_FFFD);
    applyStimulus("mulh_min", 3'd1, MIN_INT, MIN_INT);
    applyStimulus("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    applyStimulus("mulhu", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    applyStimulus("div_-7/2", 3'd4, 32'hFFFF_FFF9, 32'd2);
    applyStimulus("rem_-7/2", 3'd6, 32'hFFFF_FFF9, 32'd2);
    applyStimulus("divu_100/7", 3'd5, 32'd100, 32'd7);
    applyStimulus("remu_100/7", 3'd7, 32'd100, 32'd7);
    applyStimulus("div_by0", 3'd4, 32'd5, 32'd0);
    applyStimulus("remu_by0", 3'd7, 32'd5, 32'd0);
    applyStimulus("div_ovf", 3'd4, MIN_INT, 32'hFFFF_FFFF);
    applyStimulus("rem_ovf", 3'd6, MIN_INT, 32'hFFFF_FFFF);

    // Each call starts in the previous op's DONE cycle, so these are back-to-back.
    applyStimulus("b2b_first", 3'd0, 32'd1234, 32'd5678);
    applyStimulus("b2b_second", 3'd6, 32'hFFFF_FC00, 32'd7);

    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      rop = 3'($urandom_range(0, 7));
      applyStimulus($sformatf("rand%0d_op%0d", i, rop), rop, pickOperand(), pickOperand());
    end

    // Flush in the middle of CALC.
    @(negedge clk);
    Start = 1'b1;
    Op = 3'd4;
    A = 32'd1000;
    B = 32'd3;
    @(posedge clk);
    #1;
    Start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    Flush = 1'b1;
    @(posedge clk);
    #1;
    Flush = 1'b0;
    checkOutput("flush.ready", 32'(Ready), 32'h1);
    checkOutput("flush.done", 32'(Done), 32'h0);
    countDone(40, seen);
    checkOutput("flush.no_done", 32'(seen), 32'h0);
    checkOutput("flush.result_held", Result, lastExp);

    // Start and Flush together: request dropped.
    @(negedge clk);
    Start = 1'b1;
    Flush = 1'b1;
    Op = 3'd4;
    A = 32'd5;
    B = 32'd0;
    @(posedge clk);
    #1;
    Start = 1'b0;
    Flush = 1'b0;
    checkOutput("startflush.ready", 32'(Ready), 32'h1);
    countDone(40, seen);
    checkOutput("startflush.no_done", 32'(seen), 32'h0);
    checkOutput("startflush.result_held", Result, lastExp);

    // Reset in the middle of CALC.
    @(negedge clk);
    Start = 1'b1;
    Op = 3'd0;
    A = 32'd99;
    B = 32'd77;
    @(posedge clk);
    #1;
    Start = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("midreset.ready", 32'(Ready), 32'h1);
    checkOutput("midreset.done", 32'(Done), 32'h0);
    checkOutput("midreset.result", Result, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    countDone(40, seen);
    checkOutput("midreset.no_done", 32'(seen), 32'h0);

    applyStimulus("post_reset_div", 3'd4, 32'hFFFF_FF9C, 32'd7);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checkCount, failCount);
    $finish;
  end

endmodule
